// File: rtl/sobel_window_if.sv
// Pixel-stream input and 3x3 window output bundle for the Sobel window generator.
// The slave modport is the generator; the master modport is the pixel source / window sink.
interface sobel_window_if #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
);
    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = $clog2(IMG_H);

    logic                  in_valid;
    logic                  in_sof;
    logic [DATA_W-1:0]     in_data;
    logic                  win_valid;
    logic [9*DATA_W-1:0]   win_data;
    logic [X_W-1:0]        win_x;
    logic [Y_W-1:0]        win_y;
    logic                  frame_done;

    modport master (
        output in_valid, in_sof, in_data,
        input  win_valid, win_data, win_x, win_y, frame_done
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output win_valid, win_data, win_x, win_y, frame_done
    );
endinterface

// File: rtl/sobel_window.sv
// Streaming 3x3 neighbourhood generator: two row line buffers plus per-row column
// shift registers, emitting one registered window per interior pixel beat.
module sobel_window #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic          clk,
    input  logic          rst_n,
    sobel_window_if.slave bus
);
    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = $clog2(IMG_H);
    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);
    localparam logic [X_W-1:0] X_TWO  = X_W'(2);
    localparam logic [Y_W-1:0] Y_TWO  = Y_W'(2);
    localparam logic [X_W-1:0] X_ONE  = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);

    logic                beat;
    logic [X_W-1:0]      cur_x, x_q, x_d, win_x_q, win_x_d;
    logic [Y_W-1:0]      cur_y, y_q, y_d, win_y_q, win_y_d;
    logic [DATA_W-1:0]   lb1_q [IMG_W];
    logic [DATA_W-1:0]   lb2_q [IMG_W];
    logic [DATA_W-1:0]   col_q [3][2];
    logic [DATA_W-1:0]   new_col [3];
    logic [9*DATA_W-1:0] win_data_q, win_data_d;
    logic                win_valid_q, win_valid_d;
    logic                frame_done_q, frame_done_d;

    always_comb begin
        beat  = bus.in_valid;
        // A start-of-frame beat is (0,0) regardless of where the counters stand.
        cur_x = bus.in_sof ? '0 : x_q;
        cur_y = bus.in_sof ? '0 : y_q;

        new_col[0] = lb2_q[cur_x];
        new_col[1] = lb1_q[cur_x];
        new_col[2] = bus.in_data;

        x_d = x_q;
        y_d = y_q;
        if (beat) begin
            if (cur_x == X_LAST) begin
                x_d = '0;
                y_d = (cur_y == Y_LAST) ? '0 : cur_y + Y_ONE;
            end else begin
                x_d = cur_x + X_ONE;
                y_d = cur_y;
            end
        end

        win_valid_d  = beat && (cur_x >= X_TWO) && (cur_y >= Y_TWO);
        frame_done_d = beat && (cur_x == X_LAST) && (cur_y == Y_LAST);
        win_x_d      = cur_x - X_ONE;
        win_y_d      = cur_y - Y_ONE;

        // Columns 0 and 1 come from the shift registers; column 2 is the live column.
        win_data_d = '0;
        for (int r = 0; r < 3; r++) begin
            win_data_d[DATA_W*(3*r)     +: DATA_W] = col_q[r][0];
            win_data_d[DATA_W*(3*r + 1) +: DATA_W] = col_q[r][1];
            win_data_d[DATA_W*(3*r + 2) +: DATA_W] = new_col[r];
        end
    end

    // Line buffers are never cleared; the y>=2 gate hides stale rows.
    always_ff @(posedge clk) begin
        if (beat) begin
            lb2_q[cur_x] <= new_col[1];
            lb1_q[cur_x] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_data_q   <= '0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            for (int r = 0; r < 3; r++) begin
                col_q[r][0] <= '0;
                col_q[r][1] <= '0;
            end
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            if (beat) begin
                for (int r = 0; r < 3; r++) begin
                    col_q[r][0] <= col_q[r][1];
                    col_q[r][1] <= new_col[r];
                end
            end
            if (win_valid_d) begin
                win_data_q <= win_data_d;
                win_x_q    <= win_x_d;
                win_y_q    <= win_y_d;
            end
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.win_data   = win_data_q;
    assign bus.win_x      = win_x_q;
    assign bus.win_y      = win_y_q;
endmodule

// File: tb/tb_sobel_window.sv
// Directed bench for sobel_window on a 4x4 frame with pixel value 16*y+x.
module tb_sobel_window;
    localparam int DATA_W = 16;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int WIN_W  = 9 * DATA_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sobel_window_if #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

    sobel_window #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int mx = 0, my = 0;
    int last_x = 0, last_y = 0;
    int win_obs = 0, done_obs = 0;
    logic [WIN_W-1:0] last_win = '0;

    task automatic check(input string tag, input logic [WIN_W-1:0] obs,
                         input logic [WIN_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window whose bottom-right pixel is (x,y).
    function automatic logic [WIN_W-1:0] win_at(input int x, input int y);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[DATA_W*(3*r + c) +: DATA_W] = DATA_W'(16*(y - 2 + r) + (x - 2 + c));
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] pix(input int r, input int c);
        return bus.win_data[DATA_W*(3*r + c) +: DATA_W];
    endfunction

    task automatic beat(input bit sof);
        bit emit;
        if (sof) begin
            mx = 0;
            my = 0;
        end
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = DATA_W'(16*my + mx);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        emit = (mx >= 2) && (my >= 2);
        if (emit) begin
            last_win = win_at(mx, my);
            last_x   = mx - 1;
            last_y   = my - 1;
        end
        if (bus.win_valid)  win_obs++;
        if (bus.frame_done) done_obs++;
        check("win_valid", WIN_W'(bus.win_valid), WIN_W'(emit));
        check("frame_done", WIN_W'(bus.frame_done), WIN_W'(mx == IMG_W-1 && my == IMG_H-1));
        check("win_data", bus.win_data, last_win);
        check("win_x", WIN_W'(bus.win_x), WIN_W'(last_x));
        check("win_y", WIN_W'(bus.win_y), WIN_W'(last_y));
        if (mx == IMG_W-1) begin
            mx = 0;
            my = (my == IMG_H-1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check("idle_valid", WIN_W'(bus.win_valid), '0);
            check("idle_done", WIN_W'(bus.frame_done), '0);
            check("idle_hold", bus.win_data, last_win);
        end
    endtask

    task automatic run(input int n, input int gap_max, input bit sof_first);
        for (int i = 0; i < n; i++) begin
            beat(sof_first && (i == 0));
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, WIN_W'(bus.win_valid), '0);
        check({tag, "_done"}, WIN_W'(bus.frame_done), '0);
        check({tag, "_data"}, bus.win_data, '0);
        check({tag, "_x"}, WIN_W'(bus.win_x), '0);
        check({tag, "_y"}, WIN_W'(bus.win_y), '0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        idle(1);

        // Continuous frame; row wrap at (3,1),(0,2),(1,2) is covered by the per-beat checks.
        win_obs = 0; done_obs = 0;
        run(11, 0, 1'b1);
        check("first_centre", WIN_W'(pix(1, 1)), WIN_W'(17));
        check("first_topleft", WIN_W'(pix(0, 0)), WIN_W'(0));
        check("first_botright", WIN_W'(pix(2, 2)), WIN_W'(34));
        check("first_left_r1", WIN_W'(pix(1, 0)), WIN_W'(16));
        check("first_left_r2", WIN_W'(pix(2, 0)), WIN_W'(32));
        check("first_cx", WIN_W'(bus.win_x), WIN_W'(1));
        check("first_cy", WIN_W'(bus.win_y), WIN_W'(1));
        run(5, 0, 1'b0);
        check("cont_windows", WIN_W'(win_obs), WIN_W'(4));
        check("cont_done", WIN_W'(done_obs), WIN_W'(1));
        idle(2);

        // Random idle gaps between beats.
        win_obs = 0; done_obs = 0;
        run(16, 5, 1'b1);
        check("gap_windows", WIN_W'(win_obs), WIN_W'(4));
        check("gap_done", WIN_W'(done_obs), WIN_W'(1));

        // Two frames back to back.
        win_obs = 0; done_obs = 0;
        run(16, 0, 1'b1);
        run(16, 0, 1'b1);
        check("b2b_windows", WIN_W'(win_obs), WIN_W'(8));
        check("b2b_done", WIN_W'(done_obs), WIN_W'(2));
        idle(1);

        // Abort at (1,2) with a fresh start of frame.
        win_obs = 0; done_obs = 0;
        run(9, 0, 1'b1);
        run(16, 0, 1'b1);
        check("abort_windows", WIN_W'(win_obs), WIN_W'(4));
        check("abort_done", WIN_W'(done_obs), WIN_W'(1));
        idle(1);

        // Asynchronous reset right after the beat at (2,3).
        run(15, 0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_zero("rst_held");
        end
        rst_n    = 1'b1;
        mx       = 0;
        my       = 0;
        last_win = '0;
        last_x   = 0;
        last_y   = 0;
        win_obs  = 0;
        done_obs = 0;
        run(10, 0, 1'b0);
        check("rst_no_early", WIN_W'(win_obs), WIN_W'(0));
        run(1, 0, 1'b0);
        check("rst_first_win", WIN_W'(win_obs), WIN_W'(1));
        run(5, 0, 1'b0);
        check("rst_windows", WIN_W'(win_obs), WIN_W'(4));
        check("rst_done", WIN_W'(done_obs), WIN_W'(1));
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
